weight_loader_mk2: RTL and testbench

//  Fetches one filter's weights via axi_dma_rd and packs the DMA words into weight-SRAM rows.

---
 rtl/weight_loader_mk2.sv | 242 ++++++++++++++++++++++++
 tb/tb_weight_loader_mk2.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader_mk2.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader_mk2
// Purpose : Fetches one filter's weights over the read DMA and packs the words
//           into weight-SRAM rows (3x3 or 1x1 kernels, ping-pong bank).
// Option  : define WEIGHT_LOADER_MK2_CKSUM_EN to build the per-load byte sum.
// Rev     : 1.0 - initial release
// ============================================================================
module weight_loader_mk2 #(
    parameter int AXI_WIDTH_AD        = 32,
    parameter int AXI_WIDTH_DA        = 32,
    parameter int BITS_TRANS          = 18,
    parameter int WEIGHT_SRAM_ADDRESS = 5,
    parameter int CALC_CH_W           = 16,
    parameter int KMAX                = 9,
    parameter int DOUT_WIDTH          = KMAX * CALC_CH_W * 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ap_start,
    output logic                           ap_done,
    output logic                           ap_busy,
    output logic                           cfg_err,
    input  logic                           kernel_1x1,
    input  logic                           bank_sel,
    input  logic [8:0]                     in_ch,
    input  logic [8:0]                     weight_idx,
    input  logic [AXI_WIDTH_AD-1:0]        weight_start_addr,
    output logic                           start_dma,
    output logic [BITS_TRANS-1:0]          num_trans,
    output logic [AXI_WIDTH_AD-1:0]        start_addr,
    input  logic [AXI_WIDTH_DA-1:0]        data_o,
    input  logic                           data_vld_o,
    input  logic [BITS_TRANS-1:0]          data_cnt_o,
    input  logic                           done_o,
    output logic                           w_en,
    output logic                           w_bank,
    output logic [WEIGHT_SRAM_ADDRESS-1:0] w_addr,
    output logic [DOUT_WIDTH-1:0]          w_data,
    output logic [15:0]                    w_cksum
);

    localparam int MAX_WPR        = KMAX * CALC_CH_W * 8 / AXI_WIDTH_DA;
    localparam int BEAT_W         = $clog2(MAX_WPR + 1);
    localparam int ROWCNT_W       = WEIGHT_SRAM_ADDRESS + 1;
    localparam int BYTES_PER_BEAT = AXI_WIDTH_DA / 8;

    typedef logic [AXI_WIDTH_AD-1:0]        addr_t;
    typedef logic [BITS_TRANS-1:0]          trans_t;
    typedef logic [BEAT_W-1:0]              beat_t;
    typedef logic [ROWCNT_W-1:0]            rcnt_t;
    typedef logic [WEIGHT_SRAM_ADDRESS-1:0] waddr_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_REQ  = 3'd2,
        S_LOAD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q;
    logic            ap_done_q, ap_busy_q, cfg_err_q, start_dma_q;
    trans_t          num_trans_q;
    addr_t           start_addr_q;
    logic            w_en_q, bank_q;
    waddr_t          w_addr_q;
    logic [DOUT_WIDTH-1:0] w_data_q, pack_q, pack_d;
    logic            kernel_q;
    logic [8:0]      in_ch_q, idx_q, rows_q;
    addr_t           base_q;
    beat_t           wpr_q, beat_q;
    rcnt_t           rows_done_q;
    logic            done_flag_q;

    logic [31:0]     taps_d, wpr_d;
    logic [8:0]      rows_d;
    addr_t           bpf_d, start_addr_d;
    trans_t          num_trans_d;
    logic            cfg_bad_d, all_rows_d, last_beat_d, beat_acc_d;

    // Layer geometry, evaluated from the configuration latched at start.
    always_comb begin
        taps_d       = kernel_q ? 32'd1 : 32'(KMAX);
        wpr_d        = taps_d * 32'(CALC_CH_W) * 32'd8 / 32'(AXI_WIDTH_DA);
        rows_d       = 9'(32'(in_ch_q) / 32'(CALC_CH_W));
        bpf_d        = addr_t'(taps_d) * addr_t'(in_ch_q);
        start_addr_d = base_q + addr_t'(idx_q) * bpf_d;
        num_trans_d  = trans_t'(32'(rows_d) * wpr_d * 32'(AXI_WIDTH_DA) / 32'd32);
        cfg_bad_d    = (in_ch_q == 9'd0)
                    || ((32'(in_ch_q) % 32'(CALC_CH_W)) != 32'd0)
                    || (32'(rows_d) > (32'd1 << WEIGHT_SRAM_ADDRESS));
    end

    // Beat k of a row lands at word k, so the first beat is the row LSBs.
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < MAX_WPR; k++) begin
            if (beat_q == beat_t'(k)) begin
                pack_d[k*AXI_WIDTH_DA +: AXI_WIDTH_DA] = data_o;
            end
        end
    end

    assign all_rows_d  = (32'(rows_done_q) >= 32'(rows_q));
    assign last_beat_d = (beat_q == (wpr_q - beat_t'(1)));
    assign beat_acc_d  = (state_q == S_LOAD) && data_vld_o && !all_rows_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ap_done_q    <= 1'b0;
            ap_busy_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            start_dma_q  <= 1'b0;
            num_trans_q  <= '0;
            start_addr_q <= '0;
            w_en_q       <= 1'b0;
            bank_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            pack_q       <= '0;
            kernel_q     <= 1'b0;
            in_ch_q      <= '0;
            idx_q        <= '0;
            rows_q       <= '0;
            base_q       <= '0;
            wpr_q        <= '0;
            beat_q       <= '0;
            rows_done_q  <= '0;
            done_flag_q  <= 1'b0;
        end else begin
            start_dma_q <= 1'b0;
            w_en_q      <= 1'b0;
            ap_done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q   <= S_CALC;
                        ap_busy_q <= 1'b1;
                        cfg_err_q <= 1'b0;
                        kernel_q  <= kernel_1x1;
                        bank_q    <= bank_sel;
                        in_ch_q   <= in_ch;
                        idx_q     <= weight_idx;
                        base_q    <= weight_start_addr;
                    end
                end
                S_CALC: begin
                    start_addr_q <= start_addr_d;
                    num_trans_q  <= num_trans_d;
                    rows_q       <= rows_d;
                    wpr_q        <= beat_t'(wpr_d);
                    w_addr_q     <= '0;
                    rows_done_q  <= '0;
                    beat_q       <= '0;
                    pack_q       <= '0;
                    done_flag_q  <= 1'b0;
                    if (cfg_bad_d) begin
                        cfg_err_q <= 1'b1;
                        ap_done_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        start_dma_q <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (done_o) done_flag_q <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (done_o) done_flag_q <= 1'b1;
                    if (w_en_q) w_addr_q <= w_addr_q + waddr_t'(1);
                    if (beat_acc_d) begin
                        if (last_beat_d) begin
                            w_en_q      <= 1'b1;
                            w_data_q    <= pack_d;
                            pack_q      <= '0;
                            beat_q      <= '0;
                            rows_done_q <= rows_done_q + rcnt_t'(1);
                        end else begin
                            pack_q <= pack_d;
                            beat_q <= beat_q + beat_t'(1);
                        end
                    end
                    if (all_rows_d && done_flag_q) begin
                        ap_done_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ap_busy_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_LOADER_MK2_CKSUM_EN
    logic [15:0] cksum_q, beat_sum_d;

    always_comb begin
        beat_sum_d = 16'd0;
        for (int b = 0; b < BYTES_PER_BEAT; b++) begin
            beat_sum_d = beat_sum_d + 16'(data_o[b*8 +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= 16'd0;
        end else if (state_q == S_CALC) begin
            cksum_q <= 16'd0;
        end else if (beat_acc_d) begin
            cksum_q <= cksum_q + beat_sum_d;
        end
    end

    assign w_cksum = cksum_q;
`else
    assign w_cksum = 16'd0;
`endif

    // The DMA beat counter is informational only.
    logic unused_cnt;
    assign unused_cnt = ^data_cnt_o;

    assign ap_done    = ap_done_q;
    assign ap_busy    = ap_busy_q;
    assign cfg_err    = cfg_err_q;
    assign start_dma  = start_dma_q;
    assign num_trans  = num_trans_q;
    assign start_addr = start_addr_q;
    assign w_en       = w_en_q;
    assign w_bank     = bank_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader_mk2.sv
`default_nettype none
// Testbench for weight_loader_mk2: a table of load configurations plus a
// reset-mid-load / stray-beat sequence.
module tb_weight_loader_mk2;
    localparam int AD  = 32;
    localparam int DA  = 32;
    localparam int BT  = 18;
    localparam int WSA = 5;
    localparam int CH  = 16;
    localparam int KM  = 9;
    localparam int DW  = KM * CH * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ap_start = 1'b0;
    logic kernel_1x1 = 1'b0;
    logic bank_sel = 1'b0;
    logic [8:0] in_ch = '0;
    logic [8:0] weight_idx = '0;
    logic [AD-1:0] weight_start_addr = '0;
    logic [DA-1:0] data_o = '0;
    logic data_vld_o = 1'b0;
    logic [BT-1:0] data_cnt_o = '0;
    logic done_o = 1'b0;
    logic ap_done, ap_busy, cfg_err, start_dma, w_en, w_bank;
    logic [BT-1:0] num_trans;
    logic [AD-1:0] start_addr;
    logic [WSA-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [15:0] w_cksum;

    weight_loader_mk2 #(
        .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .BITS_TRANS(BT),
        .WEIGHT_SRAM_ADDRESS(WSA), .CALC_CH_W(CH), .KMAX(KM), .DOUT_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_busy(ap_busy), .cfg_err(cfg_err), .kernel_1x1(kernel_1x1),
        .bank_sel(bank_sel), .in_ch(in_ch), .weight_idx(weight_idx),
        .weight_start_addr(weight_start_addr), .start_dma(start_dma),
        .num_trans(num_trans), .start_addr(start_addr), .data_o(data_o),
        .data_vld_o(data_vld_o), .data_cnt_o(data_cnt_o), .done_o(done_o),
        .w_en(w_en), .w_bank(w_bank), .w_addr(w_addr), .w_data(w_data),
        .w_cksum(w_cksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_vec = -1;

    // Event monitor: cycle labels count negedges.
    int cyc = 0, n_wen = 0, n_dma = 0, n_done = 0;
    int dma_cyc = 0, done_cyc = 0, wen_cyc = 0;
    logic err_at_done = 1'b0;
    logic [15:0] ck_at_done = '0;
    logic [DW-1:0]  wr_data [64];
    logic [WSA-1:0] wr_addr [64];
    logic           wr_bank [64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (w_en) begin
            if (n_wen < 64) begin
                wr_data[n_wen] <= w_data;
                wr_addr[n_wen] <= w_addr;
                wr_bank[n_wen] <= w_bank;
            end
            n_wen   <= n_wen + 1;
            wen_cyc <= cyc + 1;
        end
        if (start_dma) begin
            n_dma   <= n_dma + 1;
            dma_cyc <= cyc + 1;
        end
        if (ap_done) begin
            n_done      <= n_done + 1;
            done_cyc    <= cyc + 1;
            err_at_done <= cfg_err;
            ck_at_done  <= w_cksum;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int i = DW/32 - 1; i >= 0; i--)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            $display("FAIL %s (vec %0d): word %0d got %h expected %h",
                     name, cur_vec, k, act[k*32 +: 32], exp[k*32 +: 32]);
        end
    endtask

    function automatic logic [31:0] beat_word(input int seed, input int b);
        return (32'(seed) * 32'h0100_0000) ^ (32'(b) * 32'h0001_0101 + 32'h0000_0011);
    endfunction

    function automatic logic [DW-1:0] exp_row(input int seed, input int r, input int wpr);
        logic [DW-1:0] row;
        row = '0;
        for (int j = 0; j < wpr; j++) row[j*32 +: 32] = beat_word(seed, r*wpr + j);
        return row;
    endfunction

    typedef struct {
        logic        k1;
        logic        bank;
        logic [8:0]  ch;
        logic [8:0]  idx;
        logic [31:0] base;
        logic        err;
        logic [31:0] exp_addr;
        logic [17:0] exp_nt;
        int          rows;
        logic        gaps;
        int          dly;    // <0: done_o with first beat; else cycles after last beat
        int          extra;  // surplus beats after the last real one
    } vec_t;

    task automatic run_vec(input vec_t v, input int seed);
        int d0, m0, w0, s, wpr, nb, tot, b, gap, lc, dc, now;
        logic [15:0] ck;
        logic [31:0] wd;
        d0 = n_done; m0 = n_dma; w0 = n_wen;
        wpr = v.k1 ? 4 : 36;
        nb  = v.rows * wpr;
        tot = nb + v.extra;
        kernel_1x1 = v.k1; bank_sel = v.bank; in_ch = v.ch;
        weight_idx = v.idx; weight_start_addr = v.base;
        ap_start = 1'b1;
        s = cyc + 1;
        tick();
        ap_start = 1'b0;
        check("busy_after_start", ap_busy, 1);
        check("cfg_err_cleared", cfg_err, 0);
        tick();
        tick();
        if (v.err) begin
            check("err_done_count", n_done - d0, 1);
            check("err_done_cycle", done_cyc - s, 2);
            check("err_flag_at_done", err_at_done, 1);
            check("err_no_dma", n_dma - m0, 0);
            check("err_flag_hold", cfg_err, 1);
            check("err_busy_idle", ap_busy, 0);
            return;
        end
        check("dma_count", n_dma - m0, 1);
        check("dma_latency", dma_cyc - s, 2);
        check("start_addr", start_addr, v.exp_addr);
        check("num_trans", num_trans, v.exp_nt);
        check("busy_load", ap_busy, 1);
        b = 0; lc = -1; dc = -1;
        gap = v.gaps ? int'($urandom_range(0, 3)) : 0;
        for (int c = 0; c < 600 && (b < tot || dc < 0); c++) begin
            now = cyc + 1;
            data_vld_o = 1'b0; done_o = 1'b0; ap_start = 1'b0;
            if (b < tot && gap == 0) begin
                data_vld_o = 1'b1;
                data_o = beat_word(seed, b);
                if (b == 0) begin
                    ap_start = 1'b1;   // must be ignored outside IDLE
                    if (v.dly < 0) begin done_o = 1'b1; dc = now; end
                end
                if (b == nb - 1) lc = now;
                b++;
                gap = v.gaps ? int'($urandom_range(0, 3)) : 0;
            end else if (b < tot) begin
                gap--;
            end
            if (v.dly >= 0 && lc >= 0 && dc < 0 && now == lc + v.dly) begin
                done_o = 1'b1; dc = now;
            end
            tick();
        end
        data_vld_o = 1'b0; done_o = 1'b0; ap_start = 1'b0;
        for (int i = 0; i < 60 && n_done == d0; i++) tick();
        check("done_count", n_done - d0, 1);
        check("done_cycle", done_cyc - ((lc > dc) ? lc : dc), 2);
        check("wen_cycle", wen_cyc - lc, 1);
        check("err_at_done", err_at_done, 0);
        check("busy_idle", ap_busy, 0);
        check("rows_written", n_wen - w0, v.rows);
        for (int r = 0; r < v.rows && w0 + r < 64; r++) begin
            check("row_addr", wr_addr[w0+r], r);
            check("row_bank", wr_bank[w0+r], v.bank);
            check_row("row_data", wr_data[w0+r], exp_row(seed, r, wpr));
        end
`ifdef WEIGHT_LOADER_MK2_CKSUM_EN
        ck = 16'd0;
        for (int i = 0; i < nb; i++) begin
            wd = beat_word(seed, i);
            for (int k = 0; k < 4; k++) ck = ck + 16'(wd[k*8 +: 8]);
        end
        check("cksum", ck_at_done, ck);
`else
        ck = 16'd0;
        wd = 32'd0;
        check("cksum_off", ck_at_done, {ck, wd[15:0]});
`endif
    endtask

    vec_t vt[8];

    initial begin
        int d0, w0;
        //          k1    bank  ch      idx    base          err   addr          nt      rows gaps dly extra
        vt[0] = '{1'b0, 1'b0, 9'd16, 9'd0, 32'h0000_0000, 1'b0, 32'd0,        18'd36, 1, 1'b0,  0, 0};
        vt[1] = '{1'b0, 1'b0, 9'd16, 9'd1, 32'h0000_0000, 1'b0, 32'd144,      18'd36, 1, 1'b0,  0, 0};
        vt[2] = '{1'b0, 1'b1, 9'd32, 9'd5, 32'h0000_0000, 1'b0, 32'd1440,     18'd72, 2, 1'b0, -1, 0};
        vt[3] = '{1'b1, 1'b1, 9'd16, 9'd2, 32'h0000_0000, 1'b0, 32'd32,       18'd4,  1, 1'b0,  5, 3};
        vt[4] = '{1'b0, 1'b0, 9'd20, 9'd0, 32'h0000_0000, 1'b1, 32'd0,        18'd0,  0, 1'b0,  0, 0};
        vt[5] = '{1'b0, 1'b0, 9'd0,  9'd3, 32'h0000_0000, 1'b1, 32'd0,        18'd0,  0, 1'b0,  0, 0};
        vt[6] = '{1'b0, 1'b0, 9'd32, 9'd1, 32'h0000_1000, 1'b0, 32'h0000_1120, 18'd72, 2, 1'b1,  5, 0};
        vt[7] = '{1'b1, 1'b1, 9'd48, 9'd3, 32'hFFFF_FFF0, 1'b0, 32'h0000_0080, 18'd12, 3, 1'b1,  0, 0};

        repeat (3) tick();
        check("rst_ap_done", ap_done, 0);
        check("rst_ap_busy", ap_busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_start_dma", start_dma, 0);
        check("rst_w_en", w_en, 0);
        check("rst_num_trans", num_trans, 0);
        check("rst_start_addr", start_addr, 0);
        check_row("rst_w_data", w_data, '0);
        rst = 1'b0;
        tick();

        for (int vi = 0; vi < 8; vi++) begin
            cur_vec = vi;
            run_vec(vt[vi], vi + 1);
            tick();
        end

        // Reset in the middle of a 3x3 load, then stray DMA beats in IDLE.
        cur_vec = 100;
        kernel_1x1 = 1'b0; bank_sel = 1'b1; in_ch = 9'd16; weight_idx = 9'd0;
        weight_start_addr = 32'h0000_0400;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 10; b++) begin
            data_vld_o = 1'b1; data_o = beat_word(77, b);
            tick();
        end
        data_vld_o = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_busy", ap_busy, 0);
        check("midrst_w_en", w_en, 0);
        check("midrst_bank", w_bank, 0);
        check("midrst_start_addr", start_addr, 0);
        check("midrst_num_trans", num_trans, 0);
        check("midrst_cksum", w_cksum, 0);
        check_row("midrst_w_data", w_data, '0);
        rst = 1'b0;
        tick();
        d0 = n_done; w0 = n_wen;
        for (int b = 10; b < 40; b++) begin
            data_vld_o = 1'b1; data_o = beat_word(77, b);
            done_o = (b == 39);
            tick();
        end
        data_vld_o = 1'b0; done_o = 1'b0;
        repeat (3) tick();
        check("stray_no_wen", n_wen - w0, 0);
        check("stray_no_done", n_done - d0, 0);
        check("stray_busy", ap_busy, 0);

        cur_vec = 0;
        run_vec(vt[0], 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
